// File: rtl/cajero_pkg.sv
// Shared definitions for the ATM keypad front end and controller:
// key codes, debounce state encoding and the amount width.
package cajero_pkg;

    localparam int unsigned ANCHO_MONTO = 32;
    localparam int unsigned ANCHO_TECLA = 4;

    localparam logic [ANCHO_TECLA-1:0] TECLA_ENTER  = 4'hA;
    localparam logic [ANCHO_TECLA-1:0] TECLA_BORRAR = 4'hB;

    typedef enum logic [1:0] {
        REPOSO     = 2'd0,
        FILTRANDO  = 2'd1,
        PRESIONADA = 2'd2,
        SOLTANDO   = 2'd3
    } estado_teclado_t;

    // Codes 0x0-0x9 are decimal digits.
    function automatic logic es_digito(input logic [ANCHO_TECLA-1:0] codigo);
        return codigo <= 4'd9;
    endfunction

endpackage

// File: rtl/antirrebote.sv
// Key debouncer: filters the raw keypad level and code into one
// single-cycle press event per accepted key, with no auto-repeat.
module antirrebote
    import cajero_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tecla_valida,
    input  logic [ANCHO_TECLA-1:0] tecla_codigo,
    output logic                   evento,
    output logic [ANCHO_TECLA-1:0] codigo
);

    localparam int unsigned ANCHO_CNT = 8;
    localparam logic [ANCHO_CNT-1:0] LIMITE = ANCHO_CNT'(DEBOUNCE_CYCLES);
    localparam logic [ANCHO_CNT-1:0] UNO    = ANCHO_CNT'(1);

    estado_teclado_t        estado_q, estado_d;
    logic [ANCHO_CNT-1:0]   cnt_q, cnt_d;
    logic [ANCHO_TECLA-1:0] codigo_q, codigo_d;
    logic                   evento_q, evento_d;
    logic [ANCHO_CNT-1:0]   cnt_sig;

    // The counter never exceeds LIMITE-1, so the increment cannot wrap.
    assign cnt_sig = cnt_q + UNO;

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        codigo_d = codigo_q;
        evento_d = 1'b0;
        case (estado_q)
            REPOSO: begin
                if (tecla_valida) begin
                    estado_d = FILTRANDO;
                    codigo_d = tecla_codigo;
                    cnt_d    = UNO;
                end
            end
            FILTRANDO: begin
                if (!tecla_valida) begin
                    estado_d = REPOSO;
                    cnt_d    = '0;
                end else if (tecla_codigo != codigo_q) begin
                    codigo_d = tecla_codigo;
                    cnt_d    = UNO;
                end else if (cnt_sig >= LIMITE) begin
                    estado_d = PRESIONADA;
                    evento_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_sig;
                end
            end
            PRESIONADA: begin
                if (!tecla_valida) begin
                    estado_d = SOLTANDO;
                    cnt_d    = UNO;
                end
            end
            SOLTANDO: begin
                if (tecla_valida) begin
                    estado_d = PRESIONADA;
                    cnt_d    = '0;
                end else if (cnt_sig >= LIMITE) begin
                    estado_d = REPOSO;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_sig;
                end
            end
            default: begin
                estado_d = REPOSO;
                cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= REPOSO;
            cnt_q    <= '0;
            codigo_q <= '0;
            evento_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            codigo_q <= codigo_d;
            evento_q <= evento_d;
        end
    end

    assign evento = evento_q;
    assign codigo = codigo_q;

endmodule

// File: rtl/teclado_cajero.sv
// Keypad front end for the ATM controller: turns debounced key events into
// PIN digit strobes or a decimal-assembled amount, depending on the entry mode.
module teclado_cajero
    import cajero_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned MAX_DIGITOS     = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tecla_valida,
    input  logic [ANCHO_TECLA-1:0] tecla_codigo,
    input  logic                   modo_monto,
    output logic [ANCHO_TECLA-1:0] digito,
    output logic                   digito_stb,
    output logic [ANCHO_MONTO-1:0] monto,
    output logic                   monto_stb,
    output logic                   desborde
);

    localparam int unsigned ANCHO_CUENTA = 4;
    localparam logic [ANCHO_CUENTA-1:0] LIMITE_DIGITOS = ANCHO_CUENTA'(MAX_DIGITOS);

    logic                   evento;
    logic [ANCHO_TECLA-1:0] codigo;

    antirrebote #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_antirrebote (
        .clk          (clk),
        .reset        (reset),
        .tecla_valida (tecla_valida),
        .tecla_codigo (tecla_codigo),
        .evento       (evento),
        .codigo       (codigo)
    );

    logic [ANCHO_MONTO-1:0]  acc_q, acc_d;
    logic [ANCHO_CUENTA-1:0] cuenta_q, cuenta_d;
    logic                    modo_q;
    logic [ANCHO_TECLA-1:0]  digito_q, digito_d;
    logic                    digito_stb_q, digito_stb_d;
    logic [ANCHO_MONTO-1:0]  monto_q, monto_d;
    logic                    monto_stb_q, monto_stb_d;
    logic                    desborde_q, desborde_d;

    // A mode change empties the accumulator before any same-cycle event uses it.
    logic                    cambio_modo;
    logic [ANCHO_MONTO-1:0]  acc_base;
    logic [ANCHO_CUENTA-1:0] cuenta_base;

    assign cambio_modo = (modo_monto != modo_q);
    assign acc_base    = cambio_modo ? '0 : acc_q;
    assign cuenta_base = cambio_modo ? '0 : cuenta_q;

    always_comb begin
        acc_d        = acc_base;
        cuenta_d     = cuenta_base;
        digito_d     = digito_q;
        monto_d      = monto_q;
        digito_stb_d = 1'b0;
        monto_stb_d  = 1'b0;
        desborde_d   = 1'b0;
        if (evento) begin
            if (!modo_monto) begin
                if (es_digito(codigo)) begin
                    digito_d     = codigo;
                    digito_stb_d = 1'b1;
                end
            end else if (es_digito(codigo)) begin
                if (cuenta_base < LIMITE_DIGITOS) begin
                    acc_d    = ANCHO_MONTO'(acc_base * ANCHO_MONTO'(10)) + ANCHO_MONTO'(codigo);
                    cuenta_d = cuenta_base + ANCHO_CUENTA'(1);
                end else begin
                    desborde_d = 1'b1;
                end
            end else if (codigo == TECLA_ENTER) begin
                if (cuenta_base != '0) begin
                    monto_d     = acc_base;
                    monto_stb_d = 1'b1;
                    acc_d       = '0;
                    cuenta_d    = '0;
                end
            end else if (codigo == TECLA_BORRAR) begin
                acc_d    = '0;
                cuenta_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q        <= '0;
            cuenta_q     <= '0;
            modo_q       <= 1'b0;
            digito_q     <= '0;
            digito_stb_q <= 1'b0;
            monto_q      <= '0;
            monto_stb_q  <= 1'b0;
            desborde_q   <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cuenta_q     <= cuenta_d;
            modo_q       <= modo_monto;
            digito_q     <= digito_d;
            digito_stb_q <= digito_stb_d;
            monto_q      <= monto_d;
            monto_stb_q  <= monto_stb_d;
            desborde_q   <= desborde_d;
        end
    end

    assign digito     = digito_q;
    assign digito_stb = digito_stb_q;
    assign monto      = monto_q;
    assign monto_stb  = monto_stb_q;
    assign desborde   = desborde_q;

endmodule

// File: tb/tb_teclado_cajero.sv
// Bench for teclado_cajero: key-press table, hand-written corner sequences and
// random traffic, all checked every cycle against a behavioural keypad model.
module tb_teclado_cajero;
    import cajero_pkg::*;

    localparam int unsigned D    = 4;
    localparam int unsigned MAXD = 9;

    localparam int NADA = 0;
    localparam int DIG  = 1;
    localparam int MON  = 2;
    localparam int DES  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        tecla_valida;
    logic [3:0]  tecla_codigo;
    logic        modo_monto;
    logic [3:0]  digito;
    logic        digito_stb;
    logic [31:0] monto;
    logic        monto_stb;
    logic        desborde;

    teclado_cajero #(
        .DEBOUNCE_CYCLES (D),
        .MAX_DIGITOS     (MAXD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tecla_valida (tecla_valida),
        .tecla_codigo (tecla_codigo),
        .modo_monto   (modo_monto),
        .digito       (digito),
        .digito_stb   (digito_stb),
        .monto        (monto),
        .monto_stb    (monto_stb),
        .desborde     (desborde)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: press detection by run lengths, digits kept as a list.
    bit          m_held;
    int          m_run;
    logic [3:0]  m_run_code;
    int          m_low;
    bit          m_pend;
    logic [3:0]  m_pend_code;
    logic        m_prev_modo;
    int unsigned m_digits[$];

    logic [3:0]  e_digito;
    logic        e_dstb, e_mstb, e_desb;
    logic [31:0] e_monto;

    logic [3:0]  o_dig;
    logic        o_dstb, o_mstb, o_desb;
    logic [31:0] o_monto;

    typedef struct {
        logic [3:0]  codigo;
        logic        modo;
        int          tipo;
        logic [31:0] valor;
    } vector_t;

    vector_t tabla[$];
    int rebote[15] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0};

    task automatic chk(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
        n_checks++;
        if (actual !== esperado) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nombre, actual, esperado, $time);
        end
    endtask

    function automatic logic [31:0] valor_digitos();
        longint unsigned v = 0;
        foreach (m_digits[i]) v = v * 10 + longint'(m_digits[i]);
        return 32'(v);
    endfunction

    function automatic void aplicar(input logic [3:0] c, input logic m);
        if (!m) begin
            if (c <= 4'd9) begin
                e_digito = c;
                e_dstb   = 1'b1;
            end
        end else if (c <= 4'd9) begin
            if (m_digits.size() < MAXD) m_digits.push_back(int'(c));
            else e_desb = 1'b1;
        end else if (c == TECLA_ENTER) begin
            if (m_digits.size() > 0) begin
                e_monto = valor_digitos();
                e_mstb  = 1'b1;
                m_digits.delete();
            end
        end else if (c == TECLA_BORRAR) begin
            m_digits.delete();
        end
    endfunction

    // Predicts the outputs after the current rising edge from the sampled inputs.
    function automatic void modelo_flanco();
        if (reset) begin
            m_held = 0; m_run = 0; m_low = 0; m_pend = 0;
            m_prev_modo = 1'b0;
            m_digits.delete();
            e_digito = '0; e_dstb = 0; e_mstb = 0; e_desb = 0; e_monto = '0;
            return;
        end
        e_dstb = 0; e_mstb = 0; e_desb = 0;
        if (modo_monto != m_prev_modo) m_digits.delete();
        m_prev_modo = modo_monto;
        if (m_pend) aplicar(m_pend_code, modo_monto);
        m_pend = 0;
        if (!m_held) begin
            if (tecla_valida) begin
                if (m_run > 0 && tecla_codigo == m_run_code) m_run++;
                else begin
                    m_run      = 1;
                    m_run_code = tecla_codigo;
                end
                if (m_run == int'(D)) begin
                    m_pend      = 1;
                    m_pend_code = tecla_codigo;
                    m_held      = 1;
                    m_low       = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (!tecla_valida) begin
                m_low++;
                if (m_low == int'(D)) begin
                    m_held = 0;
                    m_run  = 0;
                end
            end else begin
                m_low = 0;
            end
        end
    endfunction

    task automatic paso();
        @(posedge clk);
        modelo_flanco();
        #1;
        o_dig = digito; o_dstb = digito_stb; o_mstb = monto_stb; o_desb = desborde; o_monto = monto;
        chk("digito_stb", 32'(digito_stb), 32'(e_dstb));
        chk("monto_stb", 32'(monto_stb), 32'(e_mstb));
        chk("desborde", 32'(desborde), 32'(e_desb));
        chk("digito", 32'(digito), 32'(e_digito));
        chk("monto", monto, e_monto);
    endtask

    task automatic pulsar(input logic [3:0] cod, input int alto, input int bajo,
                          output int n_dig, output int n_mon, output int n_des,
                          output int idx, output logic [31:0] val);
        n_dig = 0; n_mon = 0; n_des = 0; idx = -1; val = '0;
        tecla_codigo = cod;
        for (int i = 0; i < alto + bajo; i++) begin
            tecla_valida = (i < alto);
            paso();
            if (o_dstb || o_mstb || o_desb) begin
                if (idx < 0) idx = i;
                if (o_dstb) begin n_dig++; val = 32'(o_dig); end
                if (o_mstb) begin n_mon++; val = o_monto; end
                if (o_desb) n_des++;
            end
        end
    endtask

    function automatic void agregar(input logic [3:0] c, input logic m, input int t, input logic [31:0] v);
        vector_t r;
        r.codigo = c; r.modo = m; r.tipo = t; r.valor = v;
        tabla.push_back(r);
    endfunction

    initial begin
        int nd, nm, ne, idx, alto, bajo, sel;
        logic [31:0] val;
        bit rebota;

        reset = 1'b1; tecla_valida = 1'b0; tecla_codigo = '0; modo_monto = 1'b0;
        repeat (3) paso();
        chk("reset digito_stb", 32'(digito_stb), 32'd0);
        chk("reset monto", monto, 32'd0);
        reset = 1'b0;
        repeat (2) paso();

        // Key-press table: each key held 6 cycles, released 6 cycles.
        for (int k = 1; k <= 4; k++) agregar(4'(k), 1'b0, DIG, 32'(k));
        agregar(TECLA_ENTER, 1'b0, NADA, 0);
        agregar(4'hC, 1'b0, NADA, 0);
        agregar(4'd2, 1'b1, NADA, 0);
        agregar(4'd5, 1'b1, NADA, 0);
        agregar(4'd0, 1'b1, NADA, 0);
        agregar(TECLA_ENTER, 1'b1, MON, 32'd250);
        agregar(TECLA_ENTER, 1'b1, NADA, 0);
        for (int k = 0; k < 9; k++) agregar(4'd9, 1'b1, NADA, 0);
        agregar(4'd9, 1'b1, DES, 0);
        agregar(TECLA_ENTER, 1'b1, MON, 32'd999999999);
        agregar(4'd4, 1'b1, NADA, 0);
        agregar(4'd2, 1'b1, NADA, 0);
        agregar(TECLA_BORRAR, 1'b1, NADA, 0);
        agregar(4'd8, 1'b1, NADA, 0);
        agregar(TECLA_ENTER, 1'b1, MON, 32'd8);
        agregar(4'hF, 1'b1, NADA, 0);
        agregar(4'd9, 1'b0, DIG, 32'd9);

        foreach (tabla[k]) begin
            modo_monto = tabla[k].modo;
            pulsar(tabla[k].codigo, 6, 6, nd, nm, ne, idx, val);
            chk($sformatf("tabla[%0d] n_digito", k), 32'(nd), (tabla[k].tipo == DIG) ? 32'd1 : 32'd0);
            chk($sformatf("tabla[%0d] n_monto", k), 32'(nm), (tabla[k].tipo == MON) ? 32'd1 : 32'd0);
            chk($sformatf("tabla[%0d] n_desborde", k), 32'(ne), (tabla[k].tipo == DES) ? 32'd1 : 32'd0);
            if (tabla[k].tipo != NADA) chk($sformatf("tabla[%0d] latencia", k), 32'(idx), 32'(D));
            if (tabla[k].tipo == DIG || tabla[k].tipo == MON)
                chk($sformatf("tabla[%0d] valor", k), val, tabla[k].valor);
        end

        // Bouncy press and release of key 7.
        modo_monto = 1'b0; tecla_codigo = 4'd7; nd = 0; idx = -1; val = '0;
        for (int i = 0; i < 19; i++) begin
            tecla_valida = (i < 15) ? (rebote[i] != 0) : 1'b0;
            paso();
            if (o_dstb) begin nd++; if (idx < 0) idx = i; val = 32'(o_dig); end
            if (o_mstb || o_desb) nd += 10;
        end
        chk("rebote n_strobes", 32'(nd), 32'd1);
        chk("rebote ciclo", 32'(idx), 32'd9);
        chk("rebote digito", val, 32'd7);

        // Mode toggle discards a partially entered amount.
        modo_monto = 1'b1;
        pulsar(4'd5, 6, 6, nd, nm, ne, idx, val);
        modo_monto = 1'b0; tecla_valida = 1'b0;
        repeat (3) paso();
        modo_monto = 1'b1;
        repeat (2) paso();
        pulsar(TECLA_ENTER, 6, 6, nd, nm, ne, idx, val);
        chk("toggle enter sin strobe", 32'(nm), 32'd0);
        pulsar(4'd3, 6, 6, nd, nm, ne, idx, val);
        pulsar(TECLA_ENTER, 6, 6, nd, nm, ne, idx, val);
        chk("toggle monto nuevo", val, 32'd3);
        chk("toggle n_monto", 32'(nm), 32'd1);

        // Reset while key 3 is held; it must be refiltered from scratch.
        modo_monto = 1'b0;
        pulsar(4'd3, 6, 0, nd, nm, ne, idx, val);
        chk("pre-reset strobe", 32'(nd), 32'd1);
        reset = 1'b1;
        repeat (3) begin
            paso();
            chk("en reset salidas", {digito_stb, monto_stb, desborde, digito, monto[24:0]}, 32'd0);
        end
        reset = 1'b0;
        pulsar(4'd3, 10, 6, nd, nm, ne, idx, val);
        chk("post-reset n_digito", 32'(nd), 32'd1);
        chk("post-reset latencia", 32'(idx), 32'(D));
        chk("post-reset digito", val, 32'd3);

        // Random traffic with bounces, code glitches, mode flips and resets.
        for (int r = 0; r < 300; r++) begin
            if ($urandom_range(0, 7) == 0) modo_monto = !modo_monto;
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                paso();
                paso();
                reset = 1'b0;
            end
            sel = int'($urandom_range(0, 15));
            if (sel < 10) tecla_codigo = 4'(sel);
            else if (sel < 13) tecla_codigo = TECLA_ENTER;
            else if (sel < 14) tecla_codigo = TECLA_BORRAR;
            else tecla_codigo = 4'($urandom_range(12, 15));
            alto   = int'($urandom_range(1, 9));
            bajo   = int'($urandom_range(1, 10));
            rebota = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < alto + bajo; i++) begin
                if (i < alto) tecla_valida = rebota ? ($urandom_range(0, 4) != 0) : 1'b1;
                else tecla_valida = rebota ? ($urandom_range(0, 5) == 0) : 1'b0;
                if (rebota && $urandom_range(0, 9) == 0) tecla_codigo = 4'($urandom_range(0, 9));
                paso();
            end
        end

        tecla_valida = 1'b0;
        repeat (10) paso();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
